serial_adder: RTL and testbench

- Bit-serial N-bit adder built around a single 1-bit full-adder cell (i_a, i_b, i_cin -> o_sum, o_carry) plus a registered carry.
- Accepts two WIDTH-bit operands and a carry-in with a start pulse, then processes one bit per clock, LSB first.
- Presents the registered WIDTH-bit sum and the carry-out with a one-cycle done pulse.
- Sits directly above the 1-bit full adder as its sequencing and consuming stage.

---
 rtl/serial_adder_if.sv | 39 +++
 rtl/serial_adder.sv | 147 ++++++++++++++
 tb/tb_serial_adder.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder.
// The requester drives start/operands; the adder returns the registered
// result together with busy/done status.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds o_overflow.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
    logic             o_busy;
    logic             o_done;
`ifdef SERIAL_ADDER_OVF_EN
    logic             o_overflow;

    modport master (
        output i_start, i_a, i_b, i_cin,
        input  o_sum, o_carry, o_busy, o_done, o_overflow
    );

    modport slave (
        input  i_start, i_a, i_b, i_cin,
        output o_sum, o_carry, o_busy, o_done, o_overflow
    );
`else
    modport master (
        output i_start, i_a, i_b, i_cin,
        input  o_sum, o_carry, o_busy, o_done
    );

    modport slave (
        input  i_start, i_a, i_b, i_cin,
        output o_sum, o_carry, o_busy, o_done
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a registered carry,
// processing one bit per clock, LSB first.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a registered signed
// overflow flag (carry into MSB XOR carry out of MSB).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for i_start; operands captured on the accepting edge
// ADD   | one result bit per clock, LSB first; WIDTH cycles
// DONE  | o_done high for this single cycle; returns to IDLE next edge
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    serial_adder_if.slave  bus
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    // Operand A shifts out of the LSB while sum bits enter at the MSB, so
    // after WIDTH shifts this register holds the complete sum.
    logic [WIDTH-1:0] a_sum_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_shifted;
    logic             carry_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic             last_bit;

    logic             fa_sum;
    logic             fa_carry;

    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    assign last_bit = (bit_cnt == CNT_LAST);

    // Single 1-bit full-adder cell fed by the operand LSBs and the carry register.
    always_comb begin
        fa_sum   = a_sum_sr[0] ^ b_sr[0] ^ carry_reg;
        fa_carry = (a_sum_sr[0] & b_sr[0]) | (a_sum_sr[0] & carry_reg) | (b_sr[0] & carry_reg);
    end

    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_shifted = fa_sum;
        end else begin : g_wn
            assign sum_shifted = {fa_sum, a_sum_sr[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; i_start only matters in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.i_start) state_next = ADD;
            ADD:     if (last_bit)    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shift datapath: capture on accept, shift one bit per ADD cycle, publish on the last bit.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            a_sum_sr  <= '0;
            b_sr      <= '0;
            carry_reg <= 1'b0;
            bit_cnt   <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        a_sum_sr  <= bus.i_a;
                        b_sr      <= bus.i_b;
                        carry_reg <= bus.i_cin;
                        bit_cnt   <= '0;
                    end
                end
                ADD: begin
                    a_sum_sr  <= sum_shifted;
                    b_sr      <= b_sr >> 1;
                    carry_reg <= fa_carry;
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        sum_q   <= sum_shifted;
                        carry_q <= fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_reg is the carry into the MSB on the last bit.
                        ovf_q   <= carry_reg ^ fa_carry;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered status flags, derived from the state being entered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_next != IDLE);
            done_q <= (state_next == DONE);
        end
    end

    assign bus.o_sum   = sum_q;
    assign bus.o_carry = carry_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 main instance plus a WIDTH=1
// instance; results compared against plain-arithmetic reference functions.
module tb_serial_adder;

    localparam int W    = 8;
    localparam int SMAX = 2 ** (W - 1) - 1;
    localparam int SMIN = -(2 ** (W - 1));

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1)
    );

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int t;
        t = int'(a) + int'(b) + int'(cin);
        return (W + 1)'(t);
    endfunction

    function automatic bit ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(cin);
        return (s > SMAX) || (s < SMIN);
    endfunction

    // Runs one operation from IDLE; scrambles the inputs right after acceptance.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output int lat, output int ndone, output bit busy_ok, output bit early);
        logic [W-1:0] prev_sum;
        logic         prev_carry;
        prev_sum   = bus.o_sum;
        prev_carry = bus.o_carry;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_cin   = cin;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_a     = W'($urandom);
        bus.i_b     = W'($urandom);
        bus.i_cin   = 1'($urandom);
        lat     = -1;
        ndone   = 0;
        early   = 1'b0;
        busy_ok = (bus.o_busy === 1'b1);
        for (int n = 1; n <= W + 6; n++) begin
            @(posedge clk);
            #1;
            if (bus.o_busy !== ((n <= W) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
            if (bus.o_done === 1'b1) begin
                ndone++;
                if (lat < 0) lat = n;
            end
            if (ndone == 0 && (bus.o_sum !== prev_sum || bus.o_carry !== prev_carry)) early = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit quiet;
        rst_n       = 1'b0;
        bus.i_start = 1'b1;
        bus.i_a     = 8'hFF;
        bus.i_b     = 8'h00;
        bus.i_cin   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.o_sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", bus.o_sum); end
        checks++; if (bus.o_carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", bus.o_carry); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        checks++; if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
        bus.i_start = 1'b0;
        rst_n       = 1'b1;
        quiet       = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL reset_no_start: busy/done got active want idle"); end
    endtask

    task automatic test_basic();
        int lat, nd;
        bit bok, early;
        do_op(8'hA5, 8'h3C, 1'b0, lat, nd, bok, early);
        checks++; if (lat != W) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, W); end
        checks++; if (nd != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", nd); end
        checks++; if (bus.o_sum !== 8'hE1) begin errors++; $display("FAIL basic_sum: got %h want e1", bus.o_sum); end
        checks++; if (bus.o_carry !== 1'b0) begin errors++; $display("FAIL basic_carry: got %b want 0", bus.o_carry); end
        checks++; if (!bok) begin errors++; $display("FAIL basic_busy_window: got wrong busy pattern want high edges k..k+%0d", W); end
        checks++; if (early) begin errors++; $display("FAIL basic_no_partial: got output change before done want hold"); end
    endtask

    task automatic test_random();
        int lat, nd;
        bit bok, early;
        logic [W-1:0] a, b;
        logic         c;
        logic [W:0]   exp;
        do_op(8'hFF, 8'h01, 1'b1, lat, nd, bok, early);
        checks++; if ({bus.o_carry, bus.o_sum} !== 9'h101) begin errors++; $display("FAIL carry_chain: got %h want 101", {bus.o_carry, bus.o_sum}); end
        for (int i = 0; i < 100; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            exp = ref_add(a, b, c);
            do_op(a, b, c, lat, nd, bok, early);
            checks++;
            if ({bus.o_carry, bus.o_sum} !== exp) begin
                errors++;
                $display("FAIL random_result %0d: %h+%h+%b got %h want %h", i, a, b, c, {bus.o_carry, bus.o_sum}, exp);
            end
            checks++;
            if (lat != W || nd != 1 || !bok) begin
                errors++;
                $display("FAIL random_timing %0d: got lat=%0d dones=%0d busy_ok=%0b want lat=%0d dones=1 busy_ok=1", i, lat, nd, bok, W);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat, nd;
        bit idle_end;
        bus.i_a     = 8'h10;
        bus.i_b     = 8'h20;
        bus.i_cin   = 1'b0;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        lat = -1;
        nd  = 0;
        for (int n = 1; n <= W + 8; n++) begin
            @(posedge clk);
            #1;
            if (n == 2) begin
                bus.i_a     = 8'hFF;
                bus.i_b     = 8'hFF;
                bus.i_cin   = 1'b1;
                bus.i_start = 1'b1;
            end
            if (n == 4) bus.i_start = 1'b0;
            if (bus.o_done === 1'b1) begin
                nd++;
                if (lat < 0) lat = n;
            end
        end
        idle_end = (bus.o_busy === 1'b0);
        checks++; if (nd != 1 || lat != W) begin errors++; $display("FAIL ignore_done: got dones=%0d lat=%0d want dones=1 lat=%0d", nd, lat, W); end
        checks++; if ({bus.o_carry, bus.o_sum} !== 9'h030) begin errors++; $display("FAIL ignore_result: got %h want 030", {bus.o_carry, bus.o_sum}); end
        checks++; if (!idle_end) begin errors++; $display("FAIL ignore_idle: got busy want idle"); end
    endtask

    task automatic test_reset_abort();
        int lat, nd;
        bit bok, early, quiet;
        do_op(8'hFF, 8'h01, 1'b1, lat, nd, bok, early);
        bus.i_a     = 8'h5A;
        bus.i_b     = 8'h33;
        bus.i_cin   = 1'b0;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.o_sum !== 8'h00) begin errors++; $display("FAIL abort_sum: got %h want 00", bus.o_sum); end
        checks++; if (bus.o_carry !== 1'b0) begin errors++; $display("FAIL abort_carry: got %b want 0", bus.o_carry); end
        checks++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin errors++; $display("FAIL abort_status: got busy=%b done=%b want 0 0", bus.o_busy, bus.o_done); end
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL abort_no_done: got activity want idle"); end
        do_op(8'h01, 8'h01, 1'b0, lat, nd, bok, early);
        checks++; if (bus.o_sum !== 8'h02 || lat != W) begin errors++; $display("FAIL abort_recover: got sum=%h lat=%0d want sum=02 lat=%0d", bus.o_sum, lat, W); end
    endtask

    task automatic test_back_to_back();
        int done_at[$];
        int n;
        bus.i_a     = 8'hC3;
        bus.i_b     = 8'h5A;
        bus.i_cin   = 1'b1;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        for (n = 1; n <= 3 * (W + 2); n++) begin
            @(posedge clk);
            #1;
            if (bus.o_done === 1'b1) done_at.push_back(n);
        end
        bus.i_start = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
        checks++;
        if (done_at.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d dones want 3", done_at.size());
        end else if (done_at[0] != W || done_at[1] != 2 * W + 2 || done_at[2] != 3 * W + 4) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d,%0d,%0d want %0d,%0d,%0d", done_at[0], done_at[1], done_at[2], W, 2 * W + 2, 3 * W + 4);
        end
        checks++; if ({bus.o_carry, bus.o_sum} !== ref_add(8'hC3, 8'h5A, 1'b1)) begin errors++; $display("FAIL b2b_result: got %h want %h", {bus.o_carry, bus.o_sum}, ref_add(8'hC3, 8'h5A, 1'b1)); end
    endtask

    task automatic test_width1();
        logic a1, b1, c1;
        int   lat, nd;
        logic [1:0] exp;
        for (int v = 0; v < 8; v++) begin
            a1 = v[0];
            b1 = v[1];
            c1 = v[2];
            exp = 2'(int'(a1) + int'(b1) + int'(c1));
            bus1.i_a     = a1;
            bus1.i_b     = b1;
            bus1.i_cin   = c1;
            bus1.i_start = 1'b1;
            @(posedge clk);
            #1;
            bus1.i_start = 1'b0;
            lat = -1;
            nd  = 0;
            for (int n = 1; n <= 4; n++) begin
                @(posedge clk);
                #1;
                if (bus1.o_done === 1'b1) begin
                    nd++;
                    if (lat < 0) lat = n;
                end
            end
            checks++; if (lat != 1 || nd != 1) begin errors++; $display("FAIL w1_timing %0d: got lat=%0d dones=%0d want lat=1 dones=1", v, lat, nd); end
            checks++; if ({bus1.o_carry, bus1.o_sum} !== exp) begin errors++; $display("FAIL w1_result %0d: got %b want %b", v, {bus1.o_carry, bus1.o_sum}, exp); end
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_overflow();
        int lat, nd;
        bit bok, early;
        logic [W-1:0] a, b;
        logic         c;
        do_op(8'h7F, 8'h01, 1'b0, lat, nd, bok, early);
        checks++; if ({bus.o_overflow, bus.o_carry, bus.o_sum} !== 10'h280) begin errors++; $display("FAIL ovf_7f_01: got ovf=%b c=%b s=%h want 1 0 80", bus.o_overflow, bus.o_carry, bus.o_sum); end
        do_op(8'h80, 8'h80, 1'b0, lat, nd, bok, early);
        checks++; if ({bus.o_overflow, bus.o_carry, bus.o_sum} !== 10'h300) begin errors++; $display("FAIL ovf_80_80: got ovf=%b c=%b s=%h want 1 1 00", bus.o_overflow, bus.o_carry, bus.o_sum); end
        do_op(8'h05, 8'h03, 1'b0, lat, nd, bok, early);
        checks++; if ({bus.o_overflow, bus.o_sum} !== 9'h008) begin errors++; $display("FAIL ovf_05_03: got ovf=%b s=%h want 0 08", bus.o_overflow, bus.o_sum); end
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            do_op(a, b, c, lat, nd, bok, early);
            checks++;
            if (bus.o_overflow !== ref_ovf(a, b, c)) begin
                errors++;
                $display("FAIL ovf_random %0d: %h+%h+%b got %b want %b", i, a, b, c, bus.o_overflow, ref_ovf(a, b, c));
            end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_start  = 1'b0;
        bus.i_a      = '0;
        bus.i_b      = '0;
        bus.i_cin    = 1'b0;
        bus1.i_start = 1'b0;
        bus1.i_a     = '0;
        bus1.i_b     = '0;
        bus1.i_cin   = 1'b0;
        test_reset();
        test_basic();
        test_random();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_width1();
`ifdef SERIAL_ADDER_OVF_EN
        test_overflow();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
